// File: rtl/sid_regs.sv
// SID CPU register file: 6502 bus decode, voice/filter control registers,
// read-back mux with decaying bus value, and the paddle (POT) measurement FSM.
module sid_regs #(
  parameter int BUS_TTL  = 7424,
  parameter int POT_HALF = 256
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        phi2_en,
  input  logic        cs,
  input  logic        rw,
  input  logic [4:0]  addr,
  input  logic [7:0]  data_in,
  output logic [7:0]  data_out,
  output logic [15:0] v1_fcw,
  output logic [11:0] v1_pw,
  output logic [7:0]  v1_control,
  output logic [7:0]  v1_ad,
  output logic [7:0]  v1_sr,
  output logic [15:0] v2_fcw,
  output logic [11:0] v2_pw,
  output logic [7:0]  v2_control,
  output logic [7:0]  v2_ad,
  output logic [7:0]  v2_sr,
  output logic [15:0] v3_fcw,
  output logic [11:0] v3_pw,
  output logic [7:0]  v3_control,
  output logic [7:0]  v3_ad,
  output logic [7:0]  v3_sr,
  output logic [10:0] filt_fc,
  output logic [7:0]  filt_res,
  output logic [7:0]  mode_vol,
  input  logic [11:0] osc3,
  input  logic [7:0]  env3,
  input  logic        pot_x,
  input  logic        pot_y,
  output logic        pot_dump
);

  localparam int TTL_W = $clog2(BUS_TTL + 1);
  localparam logic [8:0] LAST_DUMP = 9'(POT_HALF - 1);
  localparam logic [8:0] LAST_CNT  = 9'(2 * POT_HALF - 1);

  typedef enum logic {POT_DUMP, POT_COUNT} pot_state_t;

  logic             wr_en, rd_en;
  logic [15:0]      fcw  [3];
  logic [11:0]      pw   [3];
  logic [7:0]       ctrl [3];
  logic [7:0]       ad   [3];
  logic [7:0]       sr   [3];
  logic [7:0]       bus_value;
  logic [TTL_W-1:0] ttl;
  logic [7:0]       rd_val;
  logic [7:0]       potx, poty;
  pot_state_t       pot_state, pot_state_nxt;
  logic [8:0]       phase;
  logic [7:0]       count;
  logic [7:0]       cap_x, cap_y;
  logic             got_x, got_y;
  logic             unused_osc_lsbs;

  assign wr_en = phi2_en & cs & ~rw;
  assign rd_en = phi2_en & cs & rw;
  assign unused_osc_lsbs = ^osc3[3:0];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int v = 0; v < 3; v++) begin
        fcw[v]  <= '0;
        pw[v]   <= '0;
        ctrl[v] <= '0;
        ad[v]   <= '0;
        sr[v]   <= '0;
      end
      filt_fc  <= '0;
      filt_res <= '0;
      mode_vol <= '0;
    end else if (wr_en) begin
      for (int v = 0; v < 3; v++) begin
        if (addr == 5'(7 * v))     fcw[v][7:0]  <= data_in;
        if (addr == 5'(7 * v + 1)) fcw[v][15:8] <= data_in;
        if (addr == 5'(7 * v + 2)) pw[v][7:0]   <= data_in;
        if (addr == 5'(7 * v + 3)) pw[v][11:8]  <= data_in[3:0];
        if (addr == 5'(7 * v + 4)) ctrl[v]      <= data_in;
        if (addr == 5'(7 * v + 5)) ad[v]        <= data_in;
        if (addr == 5'(7 * v + 6)) sr[v]        <= data_in;
      end
      case (addr)
        5'h15:   filt_fc[2:0]  <= data_in[2:0];
        5'h16:   filt_fc[10:3] <= data_in;
        5'h17:   filt_res      <= data_in;
        5'h18:   mode_vol      <= data_in;
        default: ;
      endcase
    end
  end

  assign v1_fcw = fcw[0];  assign v1_pw = pw[0];  assign v1_control = ctrl[0];
  assign v1_ad  = ad[0];   assign v1_sr = sr[0];
  assign v2_fcw = fcw[1];  assign v2_pw = pw[1];  assign v2_control = ctrl[1];
  assign v2_ad  = ad[1];   assign v2_sr = sr[1];
  assign v3_fcw = fcw[2];  assign v3_pw = pw[2];  assign v3_control = ctrl[2];
  assign v3_ad  = ad[2];   assign v3_sr = sr[2];

  // Last written value fades to zero once BUS_TTL idle strobes have elapsed.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      bus_value <= '0;
      ttl       <= '0;
    end else if (wr_en) begin
      bus_value <= data_in;
      ttl       <= TTL_W'(BUS_TTL);
    end else if (phi2_en && ttl != '0) begin
      ttl <= ttl - 1'b1;
      if (ttl == TTL_W'(1)) bus_value <= '0;
    end
  end

  always_comb begin
    rd_val = bus_value;
    case (addr)
      5'h19:   rd_val = potx;
      5'h1A:   rd_val = poty;
      5'h1B:   rd_val = osc3[11:4];
      5'h1C:   rd_val = env3;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) data_out <= '0;
    else if (rd_en) data_out <= rd_val;
  end

  // POT FSM: dump the capacitors for POT_HALF strobes, then time the charge.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) pot_state <= POT_DUMP;
    else          pot_state <= pot_state_nxt;
  end

  always_comb begin
    pot_state_nxt = pot_state;
    pot_dump      = 1'b0;
    case (pot_state)
      POT_DUMP: begin
        pot_dump = 1'b1;
        if (phi2_en && phase == LAST_DUMP) pot_state_nxt = POT_COUNT;
      end
      POT_COUNT: begin
        if (phi2_en && phase == LAST_CNT) pot_state_nxt = POT_DUMP;
      end
      default: pot_state_nxt = POT_DUMP;
    endcase
  end

  assign count = 8'(phase - 9'(POT_HALF));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      phase <= '0;
      cap_x <= '0;
      cap_y <= '0;
      got_x <= 1'b0;
      got_y <= 1'b0;
      potx  <= '0;
      poty  <= '0;
    end else if (phi2_en) begin
      phase <= (pot_state == POT_COUNT && phase == LAST_CNT) ? 9'd0 : phase + 9'd1;
      if (pot_state == POT_DUMP) begin
        if (phase == LAST_DUMP) begin
          got_x <= 1'b0;
          got_y <= 1'b0;
        end
      end else begin
        if (pot_x && !got_x) begin
          got_x <= 1'b1;
          cap_x <= count;
        end
        if (pot_y && !got_y) begin
          got_y <= 1'b1;
          cap_y <= count;
        end
        if (phase == LAST_CNT) begin
          potx <= got_x ? cap_x : (pot_x ? count : 8'hFF);
          poty <= got_y ? cap_y : (pot_y ? count : 8'hFF);
        end
      end
    end
  end

endmodule
